// File: rtl/terminal_pkg.sv
// Shared constants, control codes and state type for the VGA text terminal write path.
package terminal_pkg;

    localparam int unsigned WIDTH_CHARS  = 80;
    localparam int unsigned HEIGHT_CHARS = 30;
    localparam int unsigned SCREEN_CHARS = 2400;
    localparam int unsigned BANK_DEPTH   = 1024;

    localparam logic [7:0] CHAR_BS = 8'h08;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_FF = 8'h0C;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/terminal_bank_decoder.sv
// Maps a linear character address to a one-hot bank write enable and an in-bank offset.
module terminal_bank_decoder #(
    parameter int unsigned BANK_DEPTH = terminal_pkg::BANK_DEPTH
) (
    input  logic [11:0] addr_i,
    input  logic        we_i,
    output logic [2:0]  we_o,
    output logic [9:0]  offset_o
);

    localparam int unsigned BANK_BITS = $clog2(BANK_DEPTH);

    logic [11:0] bank;

    always_comb begin
        bank     = addr_i >> BANK_BITS;
        offset_o = 10'(addr_i & 12'(BANK_DEPTH - 1));
        we_o     = '0;
        if (we_i) begin
            case (bank)
                12'd0:   we_o = 3'b001;
                12'd1:   we_o = 3'b010;
                12'd2:   we_o = 3'b100;
                default: we_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/terminal_write_ctrl.sv
// Cursor tracking, control-code decode and full-screen clear for the character RAM.
// Optional: define TERMINAL_CLEAR_ON_RESET_EN to clear the screen when reset is released.
module terminal_write_ctrl #(
    parameter int unsigned WIDTH_CHARS  = terminal_pkg::WIDTH_CHARS,
    parameter int unsigned HEIGHT_CHARS = terminal_pkg::HEIGHT_CHARS,
    parameter int unsigned BANK_DEPTH   = terminal_pkg::BANK_DEPTH,
    parameter logic [7:0]  CLEAR_CHAR   = 8'h20
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  Data_i,
    input  logic        DataValid_i,
    output logic        Busy_o,
    output logic [9:0]  RamAddress_o,
    output logic [7:0]  RamData_o,
    output logic [2:0]  RamWrite_o,
    output logic [6:0]  CursorX_o,
    output logic [4:0]  CursorY_o
);

    import terminal_pkg::*;

    localparam int unsigned SCREEN = WIDTH_CHARS * HEIGHT_CHARS;

    state_t      state_q;
    logic [11:0] ptr_q, ptr_d;
    logic [6:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [11:0] clr_q;
    logic        busy_q;
    logic [9:0]  addr_q;
    logic [7:0]  data_q;
    logic [2:0]  we_q;
`ifdef TERMINAL_CLEAR_ON_RESET_EN
    logic        start_q;
`endif

    logic        wr_req;
    logic        go_clear;
    logic [11:0] dec_addr;
    logic [2:0]  dec_we;
    logic [9:0]  dec_off;

    always_comb begin
        ptr_d    = ptr_q;
        x_d      = x_q;
        y_d      = y_q;
        wr_req   = 1'b0;
        go_clear = 1'b0;
        dec_addr = ptr_q;
        if (state_q == CLEAR) begin
            dec_addr = clr_q;
            wr_req   = 1'b1;
`ifdef TERMINAL_CLEAR_ON_RESET_EN
        end else if (start_q) begin
            go_clear = 1'b1;
`endif
        end else if (DataValid_i) begin
            case (Data_i)
                CHAR_CR: begin
                    x_d   = '0;
                    ptr_d = ptr_q - {5'b0, x_q};
                end
                CHAR_LF: begin
                    // Ptr tracks Y*WIDTH+X, so a row step is +WIDTH folded back into the screen.
                    if (y_q == 5'(HEIGHT_CHARS - 1)) begin
                        y_d   = '0;
                        ptr_d = ptr_q + 12'(WIDTH_CHARS) - 12'(SCREEN);
                    end else begin
                        y_d   = y_q + 5'd1;
                        ptr_d = ptr_q + 12'(WIDTH_CHARS);
                    end
                end
                CHAR_BS: begin
                    if (x_q != '0) begin
                        x_d   = x_q - 7'd1;
                        ptr_d = ptr_q - 12'd1;
                    end
                end
                CHAR_FF: go_clear = 1'b1;
                default: begin
                    if (Data_i >= 8'h20) begin
                        wr_req = 1'b1;
                        if (ptr_q == 12'(SCREEN - 1)) begin
                            ptr_d = '0;
                            x_d   = '0;
                            y_d   = '0;
                        end else begin
                            ptr_d = ptr_q + 12'd1;
                            if (x_q == 7'(WIDTH_CHARS - 1)) begin
                                x_d = '0;
                                y_d = y_q + 5'd1;
                            end else begin
                                x_d = x_q + 7'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    terminal_bank_decoder #(
        .BANK_DEPTH(BANK_DEPTH)
    ) u_bank_decoder (
        .addr_i   (dec_addr),
        .we_i     (wr_req),
        .we_o     (dec_we),
        .offset_o (dec_off)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            clr_q   <= '0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= '0;
`ifdef TERMINAL_CLEAR_ON_RESET_EN
            start_q <= 1'b1;
`endif
        end else begin
            we_q <= dec_we;
            if (wr_req) begin
                addr_q <= dec_off;
                data_q <= (state_q == CLEAR) ? CLEAR_CHAR : Data_i;
            end
            case (state_q)
                IDLE: begin
                    ptr_q <= ptr_d;
                    x_q   <= x_d;
                    y_q   <= y_d;
`ifdef TERMINAL_CLEAR_ON_RESET_EN
                    start_q <= 1'b0;
`endif
                    if (go_clear) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        clr_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_q == 12'(SCREEN - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        clr_q   <= '0;
                        ptr_q   <= '0;
                        x_q     <= '0;
                        y_q     <= '0;
                    end else begin
                        clr_q <= clr_q + 12'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy_o       = busy_q;
    assign RamAddress_o = addr_q;
    assign RamData_o    = data_q;
    assign RamWrite_o   = we_q;
    assign CursorX_o    = x_q;
    assign CursorY_o    = y_q;

endmodule

// File: tb/tb_terminal_write_ctrl.sv
// Directed bench for terminal_write_ctrl: printable writes, wrap, control codes, clear and abort.
module tb_terminal_write_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] Data_i = '0;
    logic       DataValid_i = 1'b0;
    logic       Busy_o;
    logic [9:0] RamAddress_o;
    logic [7:0] RamData_o;
    logic [2:0] RamWrite_o;
    logic [6:0] CursorX_o;
    logic [4:0] CursorY_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    terminal_write_ctrl #(
        .WIDTH_CHARS (80),
        .HEIGHT_CHARS(30),
        .BANK_DEPTH  (1024),
        .CLEAR_CHAR  (8'h20)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Data_i      (Data_i),
        .DataValid_i (DataValid_i),
        .Busy_o      (Busy_o),
        .RamAddress_o(RamAddress_o),
        .RamData_o   (RamData_o),
        .RamWrite_o  (RamWrite_o),
        .CursorX_o   (CursorX_o),
        .CursorY_o   (CursorY_o)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge; outputs then reflect the rising edge in between.
    task automatic step(input logic v, input logic [7:0] b);
        DataValid_i = v;
        Data_i      = b;
        @(negedge Clock);
    endtask

    task automatic chk_cursor(input string tag, input int unsigned x, input int unsigned y);
        chk({tag, "_x"}, 32'(CursorX_o), x);
        chk({tag, "_y"}, 32'(CursorY_o), y);
    endtask

    // Expected {we, offset} for a linear address, by explicit bank ranges.
    function automatic logic [12:0] exp_wr(input int unsigned p);
        if (p < 1024)      return {3'b001, 10'(p)};
        else if (p < 2048) return {3'b010, 10'(p - 1024)};
        else               return {3'b100, 10'(p - 2048)};
    endfunction

    initial begin
        logic [7:0] ch;

        @(negedge Clock);
        step(1'b0, 8'h00);
        chk("rst_we", 32'(RamWrite_o), 0);
        chk("rst_busy", 32'(Busy_o), 0);
        chk("rst_addr", 32'(RamAddress_o), 0);
        chk("rst_data", 32'(RamData_o), 0);
        chk_cursor("rst", 0, 0);
        Reset = 1'b1;
        step(1'b0, 8'h00);

        step(1'b1, "A");
        chk("a_we", 32'(RamWrite_o), 32'b001);
        chk("a_addr", 32'(RamAddress_o), 0);
        chk("a_data", 32'(RamData_o), 32'h41);
        chk_cursor("a", 1, 0);
        step(1'b0, 8'h00);
        chk("a_pulse", 32'(RamWrite_o), 0);

        Reset = 1'b0;
        step(1'b0, 8'h00);
        Reset = 1'b1;
        step(1'b0, 8'h00);
        chk_cursor("rst2", 0, 0);

        for (int i = 0; i < 100; i++) begin
            ch = 8'("A" + (i % 25));
            step(1'b1, ch);
            chk("s100_wr", {19'b0, RamWrite_o, RamAddress_o}, {19'b0, exp_wr(i)});
            chk("s100_data", 32'(RamData_o), 32'(ch));
        end
        chk_cursor("s100", 20, 1);

        for (int i = 100; i < 2399; i++) begin
            step(1'b1, "k");
            chk("fill_wr", {19'b0, RamWrite_o, RamAddress_o}, {19'b0, exp_wr(i)});
        end
        chk_cursor("fill", 79, 29);
        step(1'b1, "Q");
        chk("q_we", 32'(RamWrite_o), 32'b100);
        chk("q_addr", 32'(RamAddress_o), 351);
        chk("q_data", 32'(RamData_o), 32'h51);
        chk_cursor("q_wrap", 0, 0);

        for (int i = 0; i < 245; i++) step(1'b1, "p");
        chk_cursor("pos53", 5, 3);
        step(1'b1, 8'h0D);
        chk_cursor("cr", 0, 3);
        chk("cr_we", 32'(RamWrite_o), 0);
        step(1'b1, 8'h0A);
        chk_cursor("lf", 0, 4);
        chk("lf_we", 32'(RamWrite_o), 0);
        step(1'b1, "x");
        chk("x_wr", {19'b0, RamWrite_o, RamAddress_o}, {19'b0, 3'b001, 10'd320});
        chk_cursor("x", 1, 4);
        step(1'b1, 8'h08);
        chk_cursor("bs1", 0, 4);
        step(1'b1, 8'h08);
        chk_cursor("bs0", 0, 4);
        chk("bs0_we", 32'(RamWrite_o), 0);
        step(1'b1, 8'h07);
        chk_cursor("bel", 0, 4);
        chk("bel_we", 32'(RamWrite_o), 0);
        step(1'b1, "b");
        chk("b_wr", {19'b0, RamWrite_o, RamAddress_o}, {19'b0, 3'b001, 10'd320});
        chk_cursor("b", 1, 4);
        for (int i = 0; i < 26; i++) step(1'b1, 8'h0A);
        chk_cursor("lf_wrap", 1, 0);
        step(1'b1, "c");
        chk("c_wr", {19'b0, RamWrite_o, RamAddress_o}, {19'b0, 3'b001, 10'd1});
        chk_cursor("c", 2, 0);

        step(1'b1, 8'h0C);
        chk("ff_busy", 32'(Busy_o), 1);
        chk("ff_we", 32'(RamWrite_o), 0);
        for (int k = 1; k <= 2400; k++) begin
            if (k == 1) step(1'b1, "Z");
            else        step(1'b0, 8'h00);
            chk("clr_wr", {19'b0, RamWrite_o, RamAddress_o}, {19'b0, exp_wr(k - 1)});
            chk("clr_data", 32'(RamData_o), 32'h20);
            chk("clr_busy", 32'(Busy_o), (k < 2400) ? 1 : 0);
        end
        step(1'b0, 8'h00);
        chk("clr_end_we", 32'(RamWrite_o), 0);
        chk("clr_end_busy", 32'(Busy_o), 0);
        chk_cursor("clr_end", 0, 0);

        step(1'b1, "M");
        chk_cursor("m", 1, 0);
        step(1'b1, 8'h0C);
        for (int k = 1; k < 500; k++) step(1'b0, 8'h00);
        chk("abort_pre_busy", 32'(Busy_o), 1);
        chk("abort_pre_we", 32'(RamWrite_o), 32'b001);
        chk_cursor("abort_pre", 1, 0);
        Reset = 1'b0;
        step(1'b0, 8'h00);
        chk("abort_we", 32'(RamWrite_o), 0);
        chk("abort_busy", 32'(Busy_o), 0);
        chk_cursor("abort", 0, 0);
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00);
            chk("post_abort_we", 32'(RamWrite_o), 0);
            chk("post_abort_busy", 32'(Busy_o), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
